// File: rtl/if_id_fetch_buffer.sv
// ---------------------------------------------------------------------------
// if_id_fetch_buffer
//
// Decoupling buffer between the instruction fetch stage and the decode stage
// of the pipelined MIPS datapath. It holds {instruction, PC+4} pairs in a
// DEPTH-entry circular FIFO and presents the head entry to decode
// first-word-fall-through. Data pushed at a clock edge is visible on ID_*
// right after that edge. While the buffer is empty, ID_* reads as a NOP
// (all zeros).
//
// Parameters
//   DEPTH          number of entries (power of two, >= 2)
//   DATA_WIDTH     width of the instruction and PC+4 fields
//
// Ports
//   Clk            rising-edge clock
//   Reset          asynchronous, active-low reset
//   IF_Valid       fetch presents an instruction this cycle
//   IF_Instruction fetched instruction word
//   IF_PCPlus4     PC+4 of the fetched instruction
//   IF_Ready       buffer accepts a push this cycle (fetch holds PC when low)
//   ID_Valid       head entry is valid
//   ID_Instruction head instruction, 0 when empty
//   ID_PCPlus4     head PC+4, 0 when empty
//   ID_Ready       decode consumes the head this cycle
//   Flush          discard all entries (taken branch/jump), beats push/pop
//   Count          current occupancy
// ---------------------------------------------------------------------------
module if_id_fetch_buffer #(
    parameter int DEPTH      = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      IF_Valid,
    input  logic [DATA_WIDTH-1:0]     IF_Instruction,
    input  logic [DATA_WIDTH-1:0]     IF_PCPlus4,
    output logic                      IF_Ready,
    output logic                      ID_Valid,
    output logic [DATA_WIDTH-1:0]     ID_Instruction,
    output logic [DATA_WIDTH-1:0]     ID_PCPlus4,
    input  logic                      ID_Ready,
    input  logic                      Flush,
    output logic [$clog2(DEPTH):0]    Count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] pc_mem    [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_q;

    logic push;
    logic pop;

    // Handshake flags depend only on the registered occupancy, so there is
    // no combinational path from IF_Valid/ID_Ready back to IF_Ready/ID_Valid.
    // A pop cannot free a slot for a push in the same cycle when full.
    assign IF_Ready = (count_q != CNT_W'(DEPTH));
    assign ID_Valid = (count_q != '0);

    assign push = IF_Valid & IF_Ready;
    assign pop  = ID_Valid & ID_Ready;

    assign Count = count_q;

    // First-word-fall-through head, forced to NOP when empty.
    assign ID_Instruction = ID_Valid ? instr_mem[rd_ptr] : '0;
    assign ID_PCPlus4     = ID_Valid ? pc_mem[rd_ptr]    : '0;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (Flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow is the wrap.
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; entries are only observable once written.
    always_ff @(posedge Clk) begin
        if (Reset && push && !Flush) begin
            instr_mem[wr_ptr] <= IF_Instruction;
            pc_mem[wr_ptr]    <= IF_PCPlus4;
        end
    end

endmodule

// File: tb/tb_if_id_fetch_buffer.sv
module tb_if_id_fetch_buffer;

    localparam int DEPTH      = 2;
    localparam int DATA_WIDTH = 32;

    logic                   Clk;
    logic                   Reset;
    logic                   IF_Valid;
    logic [DATA_WIDTH-1:0]  IF_Instruction;
    logic [DATA_WIDTH-1:0]  IF_PCPlus4;
    logic                   IF_Ready;
    logic                   ID_Valid;
    logic [DATA_WIDTH-1:0]  ID_Instruction;
    logic [DATA_WIDTH-1:0]  ID_PCPlus4;
    logic                   ID_Ready;
    logic                   Flush;
    logic [$clog2(DEPTH):0] Count;

    if_id_fetch_buffer #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .IF_Valid       (IF_Valid),
        .IF_Instruction (IF_Instruction),
        .IF_PCPlus4     (IF_PCPlus4),
        .IF_Ready       (IF_Ready),
        .ID_Valid       (ID_Valid),
        .ID_Instruction (ID_Instruction),
        .ID_PCPlus4     (ID_PCPlus4),
        .ID_Ready       (ID_Ready),
        .Flush          (Flush),
        .Count          (Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int assertions = 0;
    int errors     = 0;

    // Expected stream of {instruction, pc+4} that decode must receive.
    logic [63:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        assertions++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: a transfer to decode happens at the next rising edge when the
    // head is valid, decode is ready, and neither reset nor flush intervenes.
    always @(negedge Clk) begin
        if (Reset && !Flush && ID_Valid && ID_Ready) begin
            assertions++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pop: got %h/%h, required no transfer (t=%0t)",
                         ID_Instruction, ID_PCPlus4, $time);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({ID_Instruction, ID_PCPlus4} !== e) begin
                    errors++;
                    $display("FAIL pop_data: got %h/%h, required %h/%h (t=%0t)",
                             ID_Instruction, ID_PCPlus4, e[63:32], e[31:0], $time);
                end
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic rdy, input logic fl);
        IF_Valid       = v;
        IF_Instruction = ins;
        IF_PCPlus4     = pc;
        ID_Ready       = rdy;
        Flush          = fl;
    endtask

    task automatic expect_push(input logic [31:0] ins, input logic [31:0] pc);
        exp_q.push_back({ins, pc});
    endtask

    task automatic check_state(input string name, input int cnt, input logic [31:0] head_ins,
                               input logic [31:0] head_pc);
        check({name, "_count"}, 32'(Count), 32'(cnt));
        check({name, "_id_valid"}, 32'(ID_Valid), (cnt != 0) ? 32'd1 : 32'd0);
        check({name, "_if_ready"}, 32'(IF_Ready), (cnt != DEPTH) ? 32'd1 : 32'd0);
        check({name, "_id_instr"}, ID_Instruction, head_ins);
        check({name, "_id_pc"}, ID_PCPlus4, head_pc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        step();
        step();
        check_state("reset", 0, 32'h0, 32'h0);

        // Release reset together with Flush: buffer stays empty.
        Reset = 1'b1;
        drive(1'b1, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
        step();
        check_state("release_flush", 0, 32'h0, 32'h0);

        // Fill and stall.
        drive(1'b1, 32'h20080005, 32'h4, 1'b0, 1'b0);
        expect_push(32'h20080005, 32'h4);
        step();
        check_state("fill1", 1, 32'h20080005, 32'h4);
        drive(1'b1, 32'h21290001, 32'h8, 1'b0, 1'b0);
        expect_push(32'h21290001, 32'h8);
        step();
        check_state("fill2", 2, 32'h20080005, 32'h4);
        drive(1'b1, 32'h01095020, 32'hC, 1'b0, 1'b0);   // dropped: full
        step();
        check_state("full_drop", 2, 32'h20080005, 32'h4);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        step();
        check_state("drain1", 1, 32'h21290001, 32'h8);
        step();
        check_state("drain2", 0, 32'h0, 32'h0);

        // Streaming through several pointer wraps.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h2000_1000 + 32'(i), 32'(4 * (i + 1)), 1'b1, 1'b0);
            expect_push(32'h2000_1000 + 32'(i), 32'(4 * (i + 1)));
            step();
            check_state("stream", 1, 32'h2000_1000 + 32'(i), 32'(4 * (i + 1)));
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        step();
        check_state("stream_end", 0, 32'h0, 32'h0);

        // Flush priority over simultaneous push and pop.
        drive(1'b1, 32'h1000FFFF, 32'h4, 1'b0, 1'b0);
        expect_push(32'h1000FFFF, 32'h4);
        step();
        check_state("pre_flush", 1, 32'h1000FFFF, 32'h4);
        drive(1'b1, 32'h8C080000, 32'h8, 1'b1, 1'b1);
        exp_q.delete();
        step();
        check_state("flush", 0, 32'h0, 32'h0);
        drive(1'b1, 32'h00000020, 32'h8, 1'b0, 1'b0);
        expect_push(32'h00000020, 32'h8);
        step();
        check_state("post_flush", 1, 32'h00000020, 32'h8);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        step();
        check_state("post_flush_pop", 0, 32'h0, 32'h0);

        // Pops while empty have no effect.
        for (int i = 0; i < 3; i++) begin
            step();
            check_state("empty_pop", 0, 32'h0, 32'h0);
        end
        drive(1'b1, 32'hAAAA5555, 32'h40, 1'b1, 1'b0);
        expect_push(32'hAAAA5555, 32'h40);
        step();
        check_state("after_empty_pop", 1, 32'hAAAA5555, 32'h40);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        step();
        check_state("after_empty_pop_drain", 0, 32'h0, 32'h0);

        // Full with simultaneous pop: pop happens, push is refused.
        drive(1'b1, 32'h11111111, 32'h10, 1'b0, 1'b0);
        expect_push(32'h11111111, 32'h10);
        step();
        drive(1'b1, 32'h22222222, 32'h14, 1'b0, 1'b0);
        expect_push(32'h22222222, 32'h14);
        step();
        check_state("full2", 2, 32'h11111111, 32'h10);
        drive(1'b1, 32'h33333333, 32'h18, 1'b1, 1'b0);
        step();
        check_state("full_pop", 1, 32'h22222222, 32'h14);
        expect_push(32'h33333333, 32'h18);          // held instruction now accepted
        step();
        check_state("full_pop_retry", 1, 32'h33333333, 32'h18);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        step();
        check_state("full_pop_drain", 0, 32'h0, 32'h0);

        // Asynchronous reset mid-stream with Count=2.
        drive(1'b1, 32'h44444444, 32'h20, 1'b0, 1'b0);
        expect_push(32'h44444444, 32'h20);
        step();
        drive(1'b1, 32'h55555555, 32'h24, 1'b0, 1'b0);
        expect_push(32'h55555555, 32'h24);
        step();
        check_state("pre_reset", 2, 32'h44444444, 32'h20);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #2;
        Reset = 1'b0;
        exp_q.delete();
        #1;
        check_state("async_reset", 0, 32'h0, 32'h0);
        step();
        Reset = 1'b1;
        drive(1'b1, 32'h66666666, 32'h28, 1'b1, 1'b0);
        expect_push(32'h66666666, 32'h28);
        step();
        check_state("after_reset", 1, 32'h66666666, 32'h28);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        step();
        check_state("after_reset_drain", 0, 32'h0, 32'h0);

        step();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, errors);
        $finish;
    end

endmodule
